// File: rtl/lab2_proc_xm_stage_buf.sv
// lab2_proc_xm_stage_buf: X/M result queue that resolves branches and emits a one-cycle redirect
module lab2_proc_xm_stage_buf #(
  parameter int p_depth = 2,
  localparam int AW = $clog2(p_depth)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_val,
  output logic          in_rdy,
  input  logic [31:0]   in_result,
  input  logic          in_ops_eq,
  input  logic          in_ops_lt,
  input  logic          in_ops_ltu,
  input  logic [2:0]    in_br_type,
  input  logic [31:0]   in_br_target,
  input  logic [4:0]    in_rf_waddr,
  input  logic          in_rf_wen,
  input  logic          flush,
  output logic          out_val,
  input  logic          out_rdy,
  output logic [31:0]   out_result,
  output logic [4:0]    out_rf_waddr,
  output logic          out_rf_wen,
  output logic          redirect_val,
  output logic [31:0]   redirect_target,
  output logic [AW:0]   count
);
  logic [37:0]   mem_q [p_depth];
  logic [37:0]   mem_d [p_depth];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [AW:0]   count_q, count_d;
  logic          redirect_val_q, redirect_val_d;
  logic [31:0]   redirect_target_q, redirect_target_d;
  logic          is_br, taken, acc, enq, deq;
  always_comb begin
    // count < p_depth is just the MSB being clear since p_depth is a power of two
    in_rdy = reset && !flush && !count_q[AW];
    out_val = |count_q;
    is_br = in_br_type != 3'd0 && in_br_type != 3'd7;
    taken = in_br_type == 3'd1 ? in_ops_eq  :
            in_br_type == 3'd2 ? !in_ops_eq :
            in_br_type == 3'd3 ? in_ops_lt  :
            in_br_type == 3'd4 ? !in_ops_lt :
            in_br_type == 3'd5 ? in_ops_ltu :
            in_br_type == 3'd6 ? !in_ops_ltu : 1'b0;
    acc = in_val && in_rdy;
    enq = acc && !is_br;
    deq = out_val && out_rdy && !flush;
    count_d = flush ? '0 : count_q + (AW+1)'(enq) - (AW+1)'(deq);
    head_d = flush ? '0 : head_q + AW'(deq);
    tail_d = flush ? '0 : tail_q + AW'(enq);
    redirect_val_d = acc && is_br && taken;
    redirect_target_d = redirect_val_d ? in_br_target : redirect_target_q;
    mem_d = mem_q;
    if (enq) mem_d[tail_q] = {in_result, in_rf_waddr, in_rf_wen && |in_rf_waddr};
    {out_result, out_rf_waddr, out_rf_wen} = out_val ? mem_q[head_q] : '0;
    redirect_val = redirect_val_q;
    redirect_target = redirect_target_q;
    count = count_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      count_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      redirect_val_q <= 1'b0;
      redirect_target_q <= '0;
    end else begin
      count_q <= count_d;
      head_q <= head_d;
      tail_q <= tail_d;
      redirect_val_q <= redirect_val_d;
      redirect_target_q <= redirect_target_d;
    end
  always_ff @(posedge clk) mem_q <= mem_d;
endmodule

// File: tb/tb_lab2_proc_xm_stage_buf.sv
// tb_lab2_proc_xm_stage_buf: directed checks of the X/M stage buffer (depth 2, plus a depth 4 copy)
module tb_lab2_proc_xm_stage_buf;
  logic        clk, reset, in_val, in_ops_eq, in_ops_lt, in_ops_ltu, flush, out_rdy, in_rf_wen;
  logic [31:0] in_result, in_br_target;
  logic [2:0]  in_br_type;
  logic [4:0]  in_rf_waddr;
  logic        in_rdy, out_val, out_rf_wen, redirect_val;
  logic [31:0] out_result, redirect_target;
  logic [4:0]  out_rf_waddr;
  logic [1:0]  count;
  logic        in_rdy4, out_val4, out_rf_wen4, redirect_val4;
  logic [31:0] out_result4, redirect_target4;
  logic [4:0]  out_rf_waddr4;
  logic [2:0]  count4;
  int n_chk, n_err;
  lab2_proc_xm_stage_buf dut (
    .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy), .in_result(in_result),
    .in_ops_eq(in_ops_eq), .in_ops_lt(in_ops_lt), .in_ops_ltu(in_ops_ltu),
    .in_br_type(in_br_type), .in_br_target(in_br_target), .in_rf_waddr(in_rf_waddr),
    .in_rf_wen(in_rf_wen), .flush(flush), .out_val(out_val), .out_rdy(out_rdy),
    .out_result(out_result), .out_rf_waddr(out_rf_waddr), .out_rf_wen(out_rf_wen),
    .redirect_val(redirect_val), .redirect_target(redirect_target), .count(count)
  );
  lab2_proc_xm_stage_buf #(.p_depth(4)) dut4 (
    .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy4), .in_result(in_result),
    .in_ops_eq(in_ops_eq), .in_ops_lt(in_ops_lt), .in_ops_ltu(in_ops_ltu),
    .in_br_type(in_br_type), .in_br_target(in_br_target), .in_rf_waddr(in_rf_waddr),
    .in_rf_wen(in_rf_wen), .flush(flush), .out_val(out_val4), .out_rdy(out_rdy),
    .out_result(out_result4), .out_rf_waddr(out_rf_waddr4), .out_rf_wen(out_rf_wen4),
    .redirect_val(redirect_val4), .redirect_target(redirect_target4), .count(count4)
  );
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic offer(input logic [31:0] r, input logic [4:0] a, input logic w);
    in_val = 1'b1;
    in_br_type = 3'd0;
    in_result = r;
    in_rf_waddr = a;
    in_rf_wen = w;
  endtask
  task automatic branch(input logic [2:0] t, input logic [31:0] tgt);
    in_val = 1'b1;
    in_br_type = t;
    in_br_target = tgt;
  endtask
  initial begin
    n_chk = 0;
    n_err = 0;
    reset = 1'b0;
    {in_val, in_ops_eq, in_ops_lt, in_ops_ltu, flush, out_rdy, in_rf_wen} = '0;
    in_result = '0;
    in_br_target = '0;
    in_br_type = '0;
    in_rf_waddr = '0;
    #12;
    chk("rst_count", count, 0);
    chk("rst_out_val", out_val, 0);
    chk("rst_in_rdy", in_rdy, 0);
    chk("rst_redir", redirect_val, 0);
    chk("rst_redir_tgt", redirect_target, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_wen", out_rf_wen, 0);
    reset = 1'b1;
    #1;
    chk("post_rst_in_rdy", in_rdy, 1);
    // single enqueue then drain
    offer(32'h5, 5'd3, 1'b1);
    out_rdy = 1'b1;
    step();
    in_val = 1'b0;
    chk("enq_out_val", out_val, 1);
    chk("enq_out_result", out_result, 32'h5);
    chk("enq_waddr", out_rf_waddr, 3);
    chk("enq_wen", out_rf_wen, 1);
    chk("enq_count", count, 1);
    step();
    chk("deq_count", count, 0);
    chk("deq_out_val", out_val, 0);
    // backpressure fill and in-order drain with pointer wrap
    out_rdy = 1'b0;
    offer(32'hA, 5'd1, 1'b1);
    step();
    chk("fill1_count", count, 1);
    offer(32'hB, 5'd1, 1'b1);
    step();
    chk("full_count", count, 2);
    chk("full_in_rdy", in_rdy, 0);
    offer(32'hC, 5'd1, 1'b1);
    step();
    chk("full_hold_count", count, 2);
    chk("full_hold_head", out_result, 32'hA);
    out_rdy = 1'b1;
    step();
    chk("drain_a_count", count, 1);
    chk("drain_b_head", out_result, 32'hB);
    chk("drain_rdy_back", in_rdy, 1);
    step();
    in_val = 1'b0;
    chk("simul_count", count, 1);
    chk("drain_c_head", out_result, 32'hC);
    step();
    chk("drain_c_count", count, 0);
    // x0 write suppression
    out_rdy = 1'b0;
    offer(32'h77, 5'd0, 1'b1);
    step();
    in_val = 1'b0;
    chk("x0_wen", out_rf_wen, 0);
    chk("x0_result", out_result, 32'h77);
    out_rdy = 1'b1;
    step();
    chk("x0_drain", count, 0);
    out_rdy = 1'b0;
    // branch resolution
    branch(3'd2, 32'h200);
    step();
    in_val = 1'b0;
    chk("bne_redir", redirect_val, 1);
    chk("bne_tgt", redirect_target, 32'h200);
    chk("bne_count", count, 0);
    step();
    chk("bne_redir_off", redirect_val, 0);
    chk("bne_tgt_hold", redirect_target, 32'h200);
    in_ops_ltu = 1'b1;
    branch(3'd6, 32'h300);
    step();
    in_val = 1'b0;
    chk("bgeu_no_redir", redirect_val, 0);
    chk("bgeu_tgt_hold", redirect_target, 32'h200);
    chk("bgeu_count", count, 0);
    in_ops_lt = 1'b1;
    branch(3'd3, 32'h400);
    step();
    in_val = 1'b0;
    chk("blt_redir", redirect_val, 1);
    chk("blt_tgt", redirect_target, 32'h400);
    // flush both queues, then fill depth-4 copy with 2 entries plus a taken branch
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_clear4", count4, 0);
    offer(32'h11, 5'd2, 1'b1);
    step();
    offer(32'h22, 5'd2, 1'b1);
    step();
    in_ops_eq = 1'b1;
    branch(3'd1, 32'h500);
    step();
    chk("f_pre_count4", count4, 2);
    chk("f_pre_redir4", redirect_val4, 1);
    chk("f_pre_tgt4", redirect_target4, 32'h500);
    flush = 1'b1;
    out_rdy = 1'b1;
    offer(32'h33, 5'd2, 1'b1);
    step();
    flush = 1'b0;
    in_val = 1'b0;
    out_rdy = 1'b0;
    chk("flush_count4", count4, 0);
    chk("flush_out_val4", out_val4, 0);
    chk("flush_redir4", redirect_val4, 0);
    chk("flush_count2", count, 0);
    // asynchronous reset mid-stream
    offer(32'h44, 5'd4, 1'b1);
    step();
    in_val = 1'b0;
    chk("mid_count", count, 1);
    #2 reset = 1'b0;
    #1;
    chk("async_out_val", out_val, 0);
    chk("async_count", count, 0);
    chk("async_in_rdy", in_rdy, 0);
    #2 reset = 1'b1;
    step();
    chk("rel_count", count, 0);
    chk("rel_in_rdy", in_rdy, 1);
    chk("rel_out_val", out_val, 0);
    chk("rel_redir", redirect_val, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/lab2_proc_xm_stage_buf.md
LAB2_PROC_XM_STAGE_BUF -- requirements
Module: lab2_proc_xm_stage_buf

Interface
REQ-001 SHALL have parameter p_depth, default 2: number of result-queue entries; power of two, minimum 2.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port in_val, input, 1 bit: an execute-stage result is offered.
REQ-005 SHALL have port in_rdy, output, 1 bit: the block accepts the offer this cycle.
REQ-006 SHALL have port in_result, input, 32 bits: ALU output.
REQ-007 SHALL have ports in_ops_eq, in_ops_lt, in_ops_ltu, input, 1 bit each: ALU comparison flags.
REQ-008 SHALL have port in_br_type, input, 3 bits: 0 none, 1 BEQ, 2 BNE, 3 BLT, 4 BGE, 5 BLTU, 6 BGEU, 7 reserved (treated as none).
REQ-009 SHALL have port in_br_target, input, 32 bits: branch destination PC.
REQ-010 SHALL have ports in_rf_waddr (input, 5 bits) and in_rf_wen (input, 1 bit): destination register and write enable.
REQ-011 SHALL have port flush, input, 1 bit: discard all buffered state.
REQ-012 SHALL have ports out_val (output, 1 bit), out_rdy (input, 1 bit), out_result (output, 32 bits), out_rf_waddr (output, 5 bits) and out_rf_wen (output, 1 bit): downstream result stream.
REQ-013 SHALL have ports redirect_val (output, 1 bit) and redirect_target (output, 32 bits): taken-branch redirect.
REQ-014 SHALL have port count, output, clog2(p_depth)+1 bits: current queue occupancy.

Function
REQ-015 SHALL accept an input only when in_val and in_rdy are both 1 at a clock edge.
REQ-016 SHALL drive in_rdy = (count < p_depth) and reset deasserted and flush=0; in_rdy SHALL NOT depend on out_rdy.
REQ-017 SHALL enqueue an accepted input with br_type 0 or 7 at the tail as {result, waddr, wen}, forcing wen to 0 when waddr = 0.
REQ-018 SHALL NOT enqueue an accepted input with br_type 1-6 (branches are consumed here and produce no entry).
REQ-019 SHALL evaluate taken for an accepted branch as: BEQ eq; BNE !eq; BLT lt; BGE !lt; BLTU ltu; BGEU !ltu.
REQ-020 SHALL register a taken branch so that redirect_val = 1 for exactly the cycle after acceptance, with redirect_target = in_br_target; otherwise redirect_val = 0.
REQ-021 SHALL hold redirect_target at its last value while redirect_val = 0.
REQ-022 SHALL drive out_val = (count != 0) and present the head entry on the out_* data ports combinationally.
REQ-023 SHALL dequeue the head entry when out_val and out_rdy are both 1 at a clock edge.
REQ-024 SHALL, on a simultaneous enqueue and dequeue, leave count unchanged and advance both pointers.
REQ-025 SHALL wrap the head and tail pointers modulo p_depth.
REQ-026 SHALL, when full, accept no input; a dequeue in that cycle makes in_rdy = 1 in the next cycle, so the latency is one cycle.
REQ-027 SHALL hold out_* data stable while out_val = 1 and out_rdy = 0.
REQ-028 SHALL give enqueue-to-out_val a latency of one cycle (no bypass when empty).
REQ-029 SHALL, on flush = 1 at an edge, set count and both pointers to 0, ignore in_val and out_rdy, and force redirect_val = 0 in the next cycle.
REQ-030 SHALL give flush priority over a simultaneous enqueue, dequeue or redirect.

Reset
REQ-031 SHALL, while reset = 0, immediately set count = 0, both pointers = 0, out_val = 0, in_rdy = 0, redirect_val = 0 and redirect_target = 0.
REQ-032 SHALL have out_rf_wen = 0 and out_result = 0 while empty after reset, so that no stale write reaches downstream.
REQ-033 SHALL, when reset is asserted mid-operation, discard buffered entries and any pending redirect, and SHALL NOT produce a dequeue or redirect on the first edge after reset is released.
REQ-034 SHALL have in_rdy = 1 from the first cycle after reset is released.

Verification
REQ-035 SHALL cover: enqueue result 0x0000_0005, waddr 3, wen 1; out_rdy = 1 -> next cycle out_val = 1, out_result = 0x5, out_rf_waddr = 3, out_rf_wen = 1.
REQ-036 SHALL cover: out_rdy = 0 and three back-to-back inputs 0xA, 0xB, 0xC -> first two accepted, count = 2, in_rdy = 0, 0xC held; raise out_rdy -> outputs in order 0xA, 0xB, 0xC.
REQ-037 SHALL cover: BNE with eq = 0 and target 0x0000_0200 -> redirect_val = 1 for one cycle with target 0x200 and count unchanged; BGEU with ltu = 1 -> no redirect.
REQ-038 SHALL cover: write to waddr 0 with wen 1 -> out_rf_wen = 0.
REQ-039 SHALL cover: queue holds 2 entries and a taken branch is accepted, then flush next cycle -> count = 0, out_val = 0, redirect_val = 0 the following cycle.
REQ-040 SHALL cover: reset pulsed low mid-stream with count = 1 -> out_val drops asynchronously, and after release count = 0 and in_rdy = 1.
